// File: rtl/fft_mask_pkg.sv
// rtl/fft_mask_pkg.sv - shared state encoding and Q1.31 constants for fft_mask_sched
package fft_mask_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_NUM_BINS   = 257;

  localparam logic [31:0] Q31_ONE  = 32'h7FFF_FFFF;
  localparam logic [31:0] Q31_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    MRE  = 3'd3,
    MIM  = 3'd4,
    OUT  = 3'd5,
    DONE = 3'd6
  } state_e;

endpackage

// File: rtl/fft_mult.sv
// rtl/fft_mult.sv - combinational Q1.31 x Q1.31 multiplier, truncated to Q1.31
module fft_mult #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] mula_i,
  input  logic [DATA_WIDTH-1:0] mulb_i,
  output logic [DATA_WIDTH-1:0] mulout_o
);

  logic signed [2*DATA_WIDTH-1:0] a_ext;
  logic signed [2*DATA_WIDTH-1:0] b_ext;
  logic signed [2*DATA_WIDTH-1:0] prod;

  assign a_ext = $signed({{DATA_WIDTH{mula_i[DATA_WIDTH-1]}}, mula_i});
  assign b_ext = $signed({{DATA_WIDTH{mulb_i[DATA_WIDTH-1]}}, mulb_i});
  assign prod  = a_ext * b_ext;

  // Drop the redundant sign bit; arithmetic shift floors, -1 * -1 wraps.
  assign mulout_o = DATA_WIDTH'(prod >>> (DATA_WIDTH - 1));

endmodule

// File: rtl/fft_mask_sched.sv
// rtl/fft_mask_sched.sv - per-bin mask application sequencer sharing one multiplier
// Optional build macro MASK_CLAMP_EN: clamps captured mask to the non-negative range.
module fft_mask_sched
  import fft_mask_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_BINS   = DEF_NUM_BINS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fft_rd_o,
  output logic                  mask_rd_o,
  output logic [ADDR_WIDTH-1:0] bin_addr_o,
  input  logic [DATA_WIDTH-1:0] fft_re_i,
  input  logic [DATA_WIDTH-1:0] fft_im_i,
  input  logic [DATA_WIDTH-1:0] mask_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_re_o,
  output logic [DATA_WIDTH-1:0] out_im_o,
  output logic [ADDR_WIDTH-1:0] out_bin_o
);

  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_RD   = RD;
  localparam logic [2:0] ST_CAP  = CAP;
  localparam logic [2:0] ST_MRE  = MRE;
  localparam logic [2:0] ST_MIM  = MIM;
  localparam logic [2:0] ST_OUT  = OUT;
  localparam logic [2:0] ST_DONE = DONE;

  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(NUM_BINS - 1);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] bin;
  logic [DATA_WIDTH-1:0] re_q;
  logic [DATA_WIDTH-1:0] im_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] out_re;
  logic [DATA_WIDTH-1:0] out_im;
  logic [DATA_WIDTH-1:0] mask_cap;
  logic [DATA_WIDTH-1:0] mult_a;
  logic [DATA_WIDTH-1:0] mult_p;

`ifdef MASK_CLAMP_EN
  assign mask_cap = mask_i[DATA_WIDTH-1] ? '0 : mask_i;
`else
  assign mask_cap = mask_i;
`endif

  // Real part goes through the multiplier in MRE, imaginary part in MIM.
  assign mult_a = (state == ST_MIM) ? im_q : re_q;

  fft_mult #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fft_mult (
    .mula_i  (mult_a),
    .mulb_i  (mask_q),
    .mulout_o(mult_p)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      bin    <= '0;
      re_q   <= '0;
      im_q   <= '0;
      mask_q <= '0;
      out_re <= '0;
      out_im <= '0;
    end else if (abort_i) begin
      state <= ST_IDLE;
      bin   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state <= ST_RD;
            bin   <= '0;
          end
        end
        ST_RD:  state <= ST_CAP;
        ST_CAP: begin
          re_q   <= fft_re_i;
          im_q   <= fft_im_i;
          mask_q <= mask_cap;
          state  <= ST_MRE;
        end
        ST_MRE: begin
          out_re <= mult_p;
          state  <= ST_MIM;
        end
        ST_MIM: begin
          out_im <= mult_p;
          state  <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready_i) begin
            if (bin == LAST_BIN) begin
              state <= ST_DONE;
            end else begin
              bin   <= bin + 1'b1;
              state <= ST_RD;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          bin   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          bin   <= '0;
        end
      endcase
    end
  end

  assign busy_o      = (state != ST_IDLE);
  assign done_o      = (state == ST_DONE);
  assign fft_rd_o    = (state == ST_RD);
  assign mask_rd_o   = (state == ST_RD);
  assign bin_addr_o  = bin;
  assign out_valid_o = (state == ST_OUT);
  assign out_re_o    = out_re;
  assign out_im_o    = out_im;
  assign out_bin_o   = bin;

endmodule
